// File: rtl/lgn_pkg.sv
// lgn_pkg: shared defaults and types for the lgn_group_argmax classification head.
//   CLASSES / GROUP_SIZE : default class-group geometry
//   IN_W                 : width of the network output vector
//   SCORE_W / CLASS_W    : popcount width and class index width
//   state_e              : argmax FSM states
//   score_t              : popcount score type for the default geometry
package lgn_pkg;

  localparam int CLASSES    = 5;
  localparam int GROUP_SIZE = 3;
  localparam int IN_W       = CLASSES * GROUP_SIZE;
  localparam int SCORE_W    = $clog2(GROUP_SIZE + 1);
  localparam int CLASS_W    = (CLASSES > 1) ? $clog2(CLASSES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [SCORE_W-1:0] score_t;

endpackage

// File: rtl/lgn_popcount.sv
// lgn_popcount: combinational popcount of one class group.
//   bits_i  [GROUP_SIZE] : group bits
//   count_o [SCORE_W]    : number of set bits, zero-extended
module lgn_popcount #(
  parameter int GROUP_SIZE = 3,
  parameter int SCORE_W    = $clog2(GROUP_SIZE + 1)
) (
  input  logic [GROUP_SIZE-1:0] bits_i,
  output logic [SCORE_W-1:0]    count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      count_o = count_o + SCORE_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/lgn_group_argmax.sv
// lgn_group_argmax: splits a registered network output vector into class
// groups, popcounts each group, then scans the counts one per cycle to find
// the winning class (ties go to the lowest index).
//
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   in_data/in_valid      : input vector and its valid
//   in_ready              : high only in IDLE
//   out_class/out_valid   : winning class index and its valid
//   out_score             : winner popcount (only with LGN_ARGMAX_SCORE_OUT_EN)
//   out_ready             : consumer accepts the result
//
// Build option: define LGN_ARGMAX_SCORE_OUT_EN to expose out_score.
//
// state | meaning
// IDLE  | waiting for a vector, in_ready=1
// COUNT | latch all group popcounts, clear best
// SCAN  | compare one count per cycle against best
// DONE  | result presented, out_valid=1
module lgn_group_argmax
  import lgn_pkg::*;
#(
  parameter int CLASSES    = lgn_pkg::CLASSES,
  parameter int GROUP_SIZE = lgn_pkg::GROUP_SIZE,
  parameter int SCORE_W    = $clog2(GROUP_SIZE + 1),
  parameter int CLASS_W    = (CLASSES > 1) ? $clog2(CLASSES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CLASSES*GROUP_SIZE-1:0] in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [CLASS_W-1:0]            out_class,
`ifdef LGN_ARGMAX_SCORE_OUT_EN
  output logic [SCORE_W-1:0]            out_score,
`endif
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(CLASSES - 1);

  state_e state_q, state_d;

  logic [CLASSES*GROUP_SIZE-1:0] data_q;
  logic [SCORE_W-1:0]            pop_w   [CLASSES];
  logic [SCORE_W-1:0]            count_q [CLASSES];
  logic [CLASS_W-1:0]            idx_q;
  logic [SCORE_W-1:0]            best_score_q;
  logic [CLASS_W-1:0]            best_idx_q;
  logic [CLASS_W-1:0]            out_class_q;

  logic [SCORE_W-1:0]            cand;
  logic                          take;
  logic [SCORE_W-1:0]            win_score;
  logic [CLASS_W-1:0]            win_idx;

  for (genvar k = 0; k < CLASSES; k++) begin : g_pop
    lgn_popcount #(
      .GROUP_SIZE(GROUP_SIZE),
      .SCORE_W   (SCORE_W)
    ) u_pop (
      .bits_i (data_q[k*GROUP_SIZE +: GROUP_SIZE]),
      .count_o(pop_w[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = COUNT;
      end
      COUNT: state_d = SCAN;
      SCAN:  if (idx_q == LAST_IDX) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strict greater-than keeps the incumbent on ties. The final winner is taken
  // from this compare directly so the last element is not missed.
  always_comb begin
    cand      = count_q[idx_q];
    take      = cand > best_score_q;
    win_score = take ? cand  : best_score_q;
    win_idx   = take ? idx_q : best_idx_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q       <= '0;
      idx_q        <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      out_class_q  <= '0;
      for (int k = 0; k < CLASSES; k++) count_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) data_q <= in_data;
        COUNT: begin
          for (int k = 0; k < CLASSES; k++) count_q[k] <= pop_w[k];
          idx_q        <= '0;
          best_score_q <= '0;
          best_idx_q   <= '0;
        end
        SCAN: begin
          best_score_q <= win_score;
          best_idx_q   <= win_idx;
          if (idx_q == LAST_IDX) begin
            out_class_q <= win_idx;
            idx_q       <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_class = out_class_q;

`ifdef LGN_ARGMAX_SCORE_OUT_EN
  logic [SCORE_W-1:0] out_score_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    out_score_q <= '0;
    else if (state_q == SCAN && idx_q == LAST_IDX) out_score_q <= win_score;
  end

  assign out_score = out_score_q;
`endif

endmodule

// File: tb/tb_lgn_group_argmax.sv
module tb_lgn_group_argmax;

  localparam int C = 5;
  localparam int G = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  out_class;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef LGN_ARGMAX_SCORE_OUT_EN
  logic [1:0]  out_score;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  lgn_group_argmax dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_class(out_class),
`ifdef LGN_ARGMAX_SCORE_OUT_EN
    .out_score(out_score),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference: score of each class is its bit count; winner is the lowest
  // class whose count equals the maximum count.
  function automatic void model(input logic [14:0] v, output int cls, output int sc);
    int cnt[C];
    int mx;
    mx = 0;
    for (int k = 0; k < C; k++) begin
      cnt[k] = $countones(v[k*G +: G]);
      if (cnt[k] > mx) mx = cnt[k];
    end
    sc = mx;
    cls = -1;
    for (int k = 0; k < C; k++) if (cls < 0 && cnt[k] == mx) cls = k;
  endfunction

  // Drives one vector, returns edges from acceptance to out_valid seen high.
  task automatic run_txn(input logic [14:0] d, input logic rdy, output int lat);
    int w;
    @(negedge clk);
    in_data = d; in_valid = 1'b1; out_ready = rdy;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk);
    #1 in_valid = 1'b0; in_data = 15'($urandom);
    lat = 0;
    while (lat < 30) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_class !== 3'd0) begin
        failures++;
        $display("FAIL reset_state: in_ready=%b out_valid=%b out_class=%0d required 1 0 0",
                 in_ready, out_valid, out_class);
      end
`ifdef LGN_ARGMAX_SCORE_OUT_EN
      checks++;
      if (out_score !== 2'd0) begin
        failures++;
        $display("FAIL reset_score: got %0d required 0", out_score);
      end
`endif
    end
    reset = 1'b0;
  endtask

  task automatic test_unique();
    int lat;
    run_txn(15'h7000, 1'b1, lat);
    checks++;
    if (lat != 6) begin
      failures++; $display("FAIL unique_latency: got %0d required 6", lat);
    end
    checks++;
    if (out_class !== 3'd4) begin
      failures++; $display("FAIL unique_class: got %0d required 4", out_class);
    end
`ifdef LGN_ARGMAX_SCORE_OUT_EN
    checks++;
    if (out_score !== 2'd3) begin
      failures++; $display("FAIL unique_score: got %0d required 3", out_score);
    end
`endif
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL unique_return_idle: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_fixed_patterns();
    logic [14:0] vec [3];
    int          ecls [3];
    int          esc  [3];
    int          lat;
    vec[0] = 15'h0618; ecls[0] = 1; esc[0] = 2;
    vec[1] = 15'h0000; ecls[1] = 0; esc[1] = 0;
    vec[2] = 15'h7FFF; ecls[2] = 0; esc[2] = 3;
    for (int i = 0; i < 3; i++) begin
      run_txn(vec[i], 1'b1, lat);
      checks++;
      if (lat != 6 || out_class !== 3'(ecls[i])) begin
        failures++;
        $display("FAIL pattern_%0d class: vec=%h lat=%0d class=%0d required lat 6 class %0d",
                 i, vec[i], lat, out_class, ecls[i]);
      end
`ifdef LGN_ARGMAX_SCORE_OUT_EN
      checks++;
      if (out_score !== 2'(esc[i])) begin
        failures++;
        $display("FAIL pattern_%0d score: got %0d required %0d", i, out_score, esc[i]);
      end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_back_pressure();
    int lat, ecls, esc;
    logic [14:0] v;
    run_txn(15'h7000, 1'b0, lat);
    checks++;
    if (lat != 6) begin
      failures++; $display("FAIL bp_latency: got %0d required 6", lat);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 in_valid = 1'($urandom); in_data = 15'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_class !== 3'd4 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: out_valid=%b out_class=%0d in_ready=%b required 1 4 0",
                 i, out_valid, out_class, in_ready);
      end
`ifdef LGN_ARGMAX_SCORE_OUT_EN
      checks++;
      if (out_score !== 2'd3) begin
        failures++; $display("FAIL bp_score_%0d: got %0d required 3", i, out_score);
      end
`endif
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_class !== 3'd4) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b out_class=%0d required 1 0 4",
               in_ready, out_valid, out_class);
    end
    v = 15'($urandom);
    model(v, ecls, esc);
    run_txn(v, 1'b1, lat);
    checks++;
    if (lat != 6 || out_class !== 3'(ecls)) begin
      failures++;
      $display("FAIL bp_next: vec=%h lat=%0d class=%0d required lat 6 class %0d", v, lat, out_class, ecls);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_scan_reset();
    int lat;
    @(negedge clk);
    in_data = 15'h7FFF; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_class !== 3'd0) begin
      failures++;
      $display("FAIL midscan_reset: out_valid=%b in_ready=%b out_class=%0d required 0 1 0",
               out_valid, in_ready, out_class);
    end
    @(negedge clk);
    reset = 1'b0;
    run_txn(15'h01C0, 1'b1, lat);
    checks++;
    if (lat != 6 || out_class !== 3'd2) begin
      failures++;
      $display("FAIL midscan_next: lat=%0d class=%0d required lat 6 class 2", lat, out_class);
    end
`ifdef LGN_ARGMAX_SCORE_OUT_EN
    checks++;
    if (out_score !== 2'd3) begin
      failures++; $display("FAIL midscan_score: got %0d required 3", out_score);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    t0 = -1; t1 = -1;
    out_ready = 1'b1;
    in_data = 15'($urandom);
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        if (t0 < 0) t0 = cyc;
        else begin t1 = cyc; break; end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (t1 - t0 != C + 3) begin
      failures++;
      $display("FAIL back_to_back_period: got %0d required %0d", t1 - t0, C + 3);
    end
  endtask

  task automatic test_random();
    int lat, ecls, esc, dly;
    logic [14:0] v;
    for (int n = 0; n < 40; n++) begin
      v = 15'($urandom & $urandom);
      model(v, ecls, esc);
      dly = $urandom_range(0, 3);
      run_txn(v, (dly == 0), lat);
      checks++;
      if (lat != 6 || out_class !== 3'(ecls)) begin
        failures++;
        $display("FAIL random_%0d: vec=%h lat=%0d class=%0d required lat 6 class %0d",
                 n, v, lat, out_class, ecls);
      end
`ifdef LGN_ARGMAX_SCORE_OUT_EN
      checks++;
      if (out_score !== 2'(esc)) begin
        failures++; $display("FAIL random_score_%0d: got %0d required %0d", n, out_score, esc);
      end
`endif
      repeat (dly) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        failures++;
        $display("FAIL random_idle_%0d: in_ready=%b out_valid=%b required 1 0", n, in_ready, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unique();
    test_fixed_patterns();
    test_back_pressure();
    test_mid_scan_reset();
    test_back_to_back();
    @(negedge clk);
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
